t2c_maze_model: RTL and testbench
=================================

# t2c_maze_model

Behavioural-synthesisable maze environment for the MazeSolver bot: it holds a 9x9 wall map, tracks the bot's cell and heading, applies move commands from the explorer and returns the left/mid/right wall sensor bits. It is the sensor-producing counterpart of the explorer and closes the loop in simulation and on the FPGA self-test image.

## Interface
- START_X, 4: start column, 0..8
- START_Y, 0: start row, 0..8
- EXIT_X, 4: exit column
- EXIT_Y, 8: exit row
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- cfg_we  in  1  map write strobe, honoured only in IDLE
- cfg_addr  in  7  cell index y*9+x; values 81..127 ignored
- cfg_wdata  in  4  wall bits {W,S,E,N}, bit0 = N
- start  in  1  one-cycle pulse, begins or restarts a run
- move_valid  in  1  one-cycle strobe qualifying move
- move  in  3  0 STOP, 1 FORWARD, 2 LEFT, 3 RIGHT, 4 U_TURN
- left, mid, right  out  1  1 = wall on that side of the bot
- pos_x, pos_y  out  4  current cell
- heading  out  2  0 N (y+1), 1 E (x+1), 2 S, 3 W
- at_exit  out  1  high in DONE
- fault  out  1  high in FAULT
- move_count  out  16  accepted non-STOP moves, saturating
- uturn_count  out  4  accepted U_TURN moves, saturating at 15

## Operation
- States: IDLE, RUN, DONE, FAULT.
- IDLE: cfg_we writes map[cfg_addr] <= cfg_wdata; start -> RUN.
- RUN: on move_valid the move is decoded:
  - STOP leaves state unchanged and is not counted.
  - FORWARD / LEFT / RIGHT / U_TURN: the new heading is h, h-1, h+1 or h+2 (mod 4). The bot then advances one cell in the new heading.
  - Codes 5..7 -> FAULT.
  - A target off-grid -> FAULT.
  - With the wall check compiled in, a wall bit set on the current cell in the new heading -> FAULT.
  - On FAULT, position, heading and counters hold their pre-move values.
  - A legal move updates pos, heading and counters on the same edge. If the new cell is (EXIT_X,EXIT_Y) -> DONE.
- DONE / FAULT: move_valid and cfg_we are ignored. start restarts the run:
  - pos = start cell, heading N, counters cleared, state RUN.
  - The map is retained.
- start in RUN is ignored. start and cfg_we in the same IDLE cycle: the write is performed and the state goes to RUN.
- Sensors:
  - mid = wall in heading, left = wall in heading-1, right = wall in heading+1, all from the current cell.
  - A grid-edge side always reads 1 regardless of stored bits.
  - Sensors are driven in every state.
- The map is not symmetrised: the writer must set both sides of a shared wall.

## Timing
- Reset values:
  - state IDLE, map all 0, pos = (START_X,START_Y), heading 0.
  - Counters 0, at_exit 0, fault 0.
  - Sensors reflect the start cell with edge walls, so at (4,0) facing N: left 0, mid 0, right 0.
- Moves take effect on the rising edge that samples move_valid.
- pos, heading and the sensors are valid from the next cycle: one-cycle move-to-sensor latency.
- Sensors are combinational from registered pos, heading and map; they do not change while no move is applied.
- at_exit / fault assert in the cycle after the terminating move.
- move_valid may be asserted every cycle.
- Reset mid-run returns to IDLE immediately and clears the map; it must be reloaded.

## Configuration
- MAZE_MODEL_WALL_CHECK_EN defined: a move through a set wall bit faults, as described above.
- Not defined: wall bits affect sensors only. Moves pass through walls, and only off-grid targets and codes 5..7 fault.

## Test plan
- Reset, no writes, start, FORWARD x8 -> pos (4,8), at_exit 1, move_count 8, uturn_count 0.
- Write map[4] = 4'b0001 (N wall at (4,0)), start, read sensors -> mid 1, left 0, right 0. FORWARD with the macro defined -> fault 1, pos (4,0), move_count 0.
- Start at (4,0), RIGHT then U_TURN -> pos (5,0) heading E, then pos (4,0) heading W, uturn_count 1.
- In RUN, move = 6 with move_valid -> FAULT. start -> RUN, pos (4,0), counters 0, map intact.
- Pulse move_valid with STOP x3, then LEFT at (0,y) -> STOP leaves move_count unchanged. The off-grid LEFT gives fault 1.
- Assert rst_n low during RUN at pos (4,3) -> next cycle: IDLE, pos (4,0), map cleared, at_exit 0, fault 0.

Source files
------------

// File: rtl/t2c_maze_model.sv
// t2c_maze_model: 9x9 wall-map maze environment that tracks the bot and drives its wall sensors.
// Optional feature: define MAZE_MODEL_WALL_CHECK_EN to make moves through a set wall bit fault.
module t2c_maze_model #(
  parameter int unsigned START_X = 4,
  parameter int unsigned START_Y = 0,
  parameter int unsigned EXIT_X  = 4,
  parameter int unsigned EXIT_Y  = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_we,
  input  logic [6:0]  cfg_addr,
  input  logic [3:0]  cfg_wdata,
  input  logic        start,
  input  logic        move_valid,
  input  logic [2:0]  move,
  output logic        left,
  output logic        mid,
  output logic        right,
  output logic [3:0]  pos_x,
  output logic [3:0]  pos_y,
  output logic [1:0]  heading,
  output logic        at_exit,
  output logic        fault,
  output logic [15:0] move_count,
  output logic [3:0]  uturn_count
);

  localparam int unsigned NumCells = 81;
  localparam logic [3:0]  StartX   = 4'(START_X);
  localparam logic [3:0]  StartY   = 4'(START_Y);
  localparam logic [3:0]  ExitX    = 4'(EXIT_X);
  localparam logic [3:0]  ExitY    = 4'(EXIT_Y);

  typedef enum logic [1:0] {StIdle, StRun, StDone, StFault} state_e;

  state_e      state_q, state_d;
  logic [3:0]  map_q [NumCells];
  logic [3:0]  map_d [NumCells];
  logic [3:0]  pos_x_q, pos_x_d;
  logic [3:0]  pos_y_q, pos_y_d;
  logic [1:0]  heading_q, heading_d;
  logic [15:0] move_count_q, move_count_d;
  logic [3:0]  uturn_count_q, uturn_count_d;

  logic [6:0]  cur_idx;
  logic [3:0]  cur_walls;
  logic [3:0]  edge_walls;
  logic [3:0]  walls;
  logic [1:0]  left_dir, right_dir;
  logic [1:0]  new_hdg;
  logic [3:0]  tgt_x, tgt_y;
  logic        move_bad;
  logic        off_grid;
  logic        wall_hit;

  assign cur_idx   = 7'(pos_y_q) * 7'd9 + 7'(pos_x_q);
  assign cur_walls = map_q[cur_idx];
  // Bit order matches heading encoding: {W,S,E,N}, so walls[h] is the wall in heading h.
  assign edge_walls = {pos_x_q == 4'd0, pos_y_q == 4'd0, pos_x_q == 4'd8, pos_y_q == 4'd8};
  assign walls      = cur_walls | edge_walls;

  assign left_dir  = heading_q - 2'd1;
  assign right_dir = heading_q + 2'd1;
  assign mid       = walls[heading_q];
  assign left      = walls[left_dir];
  assign right     = walls[right_dir];

  always_comb begin
    new_hdg  = heading_q;
    move_bad = 1'b0;
    case (move)
      3'd2:                new_hdg  = heading_q - 2'd1;
      3'd3:                new_hdg  = heading_q + 2'd1;
      3'd4:                new_hdg  = heading_q + 2'd2;
      3'd5, 3'd6, 3'd7:    move_bad = 1'b1;
      default:             new_hdg  = heading_q;
    endcase

    tgt_x = pos_x_q;
    tgt_y = pos_y_q;
    case (new_hdg)
      2'd0:    tgt_y = pos_y_q + 4'd1;
      2'd1:    tgt_x = pos_x_q + 4'd1;
      2'd2:    tgt_y = pos_y_q - 4'd1;
      default: tgt_x = pos_x_q - 4'd1;
    endcase
  end

  // An edge wall in the new heading means the target cell is off the grid.
  assign off_grid = edge_walls[new_hdg];

`ifdef MAZE_MODEL_WALL_CHECK_EN
  assign wall_hit = cur_walls[new_hdg];
`else
  assign wall_hit = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    map_d         = map_q;
    pos_x_d       = pos_x_q;
    pos_y_d       = pos_y_q;
    heading_d     = heading_q;
    move_count_d  = move_count_q;
    uturn_count_d = uturn_count_q;

    unique case (state_q)
      StIdle: begin
        if (cfg_we && (cfg_addr < 7'(NumCells))) begin
          map_d[cfg_addr] = cfg_wdata;
        end
        if (start) begin
          state_d       = StRun;
          pos_x_d       = StartX;
          pos_y_d       = StartY;
          heading_d     = 2'd0;
          move_count_d  = '0;
          uturn_count_d = '0;
        end
      end

      StRun: begin
        if (move_valid && (move != 3'd0)) begin
          if (move_bad || off_grid || wall_hit) begin
            state_d = StFault;
          end else begin
            pos_x_d   = tgt_x;
            pos_y_d   = tgt_y;
            heading_d = new_hdg;
            if (move_count_q != 16'hFFFF) begin
              move_count_d = move_count_q + 16'd1;
            end
            if ((move == 3'd4) && (uturn_count_q != 4'hF)) begin
              uturn_count_d = uturn_count_q + 4'd1;
            end
            if ((tgt_x == ExitX) && (tgt_y == ExitY)) begin
              state_d = StDone;
            end
          end
        end
      end

      StDone, StFault: begin
        if (start) begin
          state_d       = StRun;
          pos_x_d       = StartX;
          pos_y_d       = StartY;
          heading_d     = 2'd0;
          move_count_d  = '0;
          uturn_count_d = '0;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      map_q         <= '{default: '0};
      pos_x_q       <= StartX;
      pos_y_q       <= StartY;
      heading_q     <= 2'd0;
      move_count_q  <= '0;
      uturn_count_q <= '0;
    end else begin
      state_q       <= state_d;
      map_q         <= map_d;
      pos_x_q       <= pos_x_d;
      pos_y_q       <= pos_y_d;
      heading_q     <= heading_d;
      move_count_q  <= move_count_d;
      uturn_count_q <= uturn_count_d;
    end
  end

  assign pos_x       = pos_x_q;
  assign pos_y       = pos_y_q;
  assign heading     = heading_q;
  assign at_exit     = (state_q == StDone);
  assign fault       = (state_q == StFault);
  assign move_count  = move_count_q;
  assign uturn_count = uturn_count_q;

endmodule

// File: tb/tb_t2c_maze_model.sv
// Self-checking bench for t2c_maze_model: a behavioural maze model feeds a scoreboard queue
// that is compared against the DUT after every driven cycle, plus directed spot checks.
module tb_t2c_maze_model;

`ifdef MAZE_MODEL_WALL_CHECK_EN
  localparam bit WallCheck = 1'b1;
`else
  localparam bit WallCheck = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_we = 1'b0;
  logic [6:0]  cfg_addr = '0;
  logic [3:0]  cfg_wdata = '0;
  logic        start = 1'b0;
  logic        move_valid = 1'b0;
  logic [2:0]  move = '0;
  logic        left, mid, right;
  logic [3:0]  pos_x, pos_y;
  logic [1:0]  heading;
  logic        at_exit, fault;
  logic [15:0] move_count;
  logic [3:0]  uturn_count;

  t2c_maze_model dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_wdata  (cfg_wdata),
    .start      (start),
    .move_valid (move_valid),
    .move       (move),
    .left       (left),
    .mid        (mid),
    .right      (right),
    .pos_x      (pos_x),
    .pos_y      (pos_y),
    .heading    (heading),
    .at_exit    (at_exit),
    .fault      (fault),
    .move_count (move_count),
    .uturn_count(uturn_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: 0 idle, 1 run, 2 done, 3 fault.
  int         m_st, m_x, m_y, m_h, m_mc, m_uc;
  logic [3:0] bmap [81];

  typedef struct {
    int px, py, hd, lf, md, rt, ex, ft, mc, uc;
  } exp_t;
  exp_t exp_q[$];

  task automatic model_reset();
    m_st = 0; m_x = 4; m_y = 0; m_h = 0; m_mc = 0; m_uc = 0;
    for (int i = 0; i < 81; i++) bmap[i] = 4'b0000;
  endtask

  task automatic model_restart();
    m_st = 1; m_x = 4; m_y = 0; m_h = 0; m_mc = 0; m_uc = 0;
  endtask

  function automatic int m_wall(input int d);
    bit e;
    e = (d == 0 && m_y == 8) || (d == 1 && m_x == 8) || (d == 2 && m_y == 0) ||
        (d == 3 && m_x == 0);
    return (e || bmap[m_y * 9 + m_x][d]) ? 1 : 0;
  endfunction

  task automatic model_step(input bit st, input bit we, input int addr, input int wd,
                            input bit mv_v, input int mv);
    int nh, nx, ny;
    case (m_st)
      0: begin
        if (we && addr < 81) bmap[addr] = 4'(wd);
        if (st) model_restart();
      end
      1: begin
        if (mv_v && mv != 0) begin
          if (mv > 4) begin
            m_st = 3;
          end else begin
            nh = (mv == 1) ? m_h : (mv == 2) ? (m_h + 3) % 4 :
                 (mv == 3) ? (m_h + 1) % 4 : (m_h + 2) % 4;
            nx = m_x + ((nh == 1) ? 1 : (nh == 3) ? -1 : 0);
            ny = m_y + ((nh == 0) ? 1 : (nh == 2) ? -1 : 0);
            if (nx < 0 || nx > 8 || ny < 0 || ny > 8 ||
                (WallCheck && bmap[m_y * 9 + m_x][nh])) begin
              m_st = 3;
            end else begin
              m_x = nx; m_y = ny; m_h = nh;
              if (m_mc < 65535) m_mc++;
              if (mv == 4 && m_uc < 15) m_uc++;
              if (m_x == 4 && m_y == 8) m_st = 2;
            end
          end
        end
      end
      default: if (st) model_restart();
    endcase
  endtask

  task automatic push_exp();
    exp_t e;
    e.px = m_x; e.py = m_y; e.hd = m_h; e.mc = m_mc; e.uc = m_uc;
    e.lf = m_wall((m_h + 3) % 4);
    e.md = m_wall(m_h);
    e.rt = m_wall((m_h + 1) % 4);
    e.ex = (m_st == 2) ? 1 : 0;
    e.ft = (m_st == 3) ? 1 : 0;
    exp_q.push_back(e);
  endtask

  task automatic drive_cycle(input bit st, input bit we, input int addr, input int wd,
                             input bit mv_v, input int mv);
    @(negedge clk);
    start      = st;
    cfg_we     = we;
    cfg_addr   = 7'(addr);
    cfg_wdata  = 4'(wd);
    move_valid = mv_v;
    move       = 3'(mv);
    model_step(st, we, addr, wd, mv_v, mv);
    push_exp();
    @(posedge clk);
    #1;
    start      = 1'b0;
    cfg_we     = 1'b0;
    move_valid = 1'b0;
  endtask

  task automatic do_move(input int mv);
    drive_cycle(1'b0, 1'b0, 0, 0, 1'b1, mv);
  endtask

  task automatic do_start();
    drive_cycle(1'b1, 1'b0, 0, 0, 1'b0, 0);
  endtask

  task automatic do_write(input int addr, input int wd);
    drive_cycle(1'b0, 1'b1, addr, wd, 1'b0, 0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_state(input string tag, input int x, input int y, input int h,
                             input int mc, input int uc, input int ex, input int ft);
    @(negedge clk);
    check_eq({tag, "_x"}, 32'(pos_x), x);
    check_eq({tag, "_y"}, 32'(pos_y), y);
    check_eq({tag, "_hdg"}, 32'(heading), h);
    check_eq({tag, "_mc"}, 32'(move_count), mc);
    check_eq({tag, "_uc"}, 32'(uturn_count), uc);
    check_eq({tag, "_exit"}, 32'(at_exit), ex);
    check_eq({tag, "_fault"}, 32'(fault), ft);
  endtask

  exp_t mon_e;
  always @(posedge clk) begin
    #2;
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      check_eq("sb_pos_x", 32'(pos_x), mon_e.px);
      check_eq("sb_pos_y", 32'(pos_y), mon_e.py);
      check_eq("sb_heading", 32'(heading), mon_e.hd);
      check_eq("sb_left", 32'(left), mon_e.lf);
      check_eq("sb_mid", 32'(mid), mon_e.md);
      check_eq("sb_right", 32'(right), mon_e.rt);
      check_eq("sb_at_exit", 32'(at_exit), mon_e.ex);
      check_eq("sb_fault", 32'(fault), mon_e.ft);
      check_eq("sb_move_count", 32'(move_count), mon_e.mc);
      check_eq("sb_uturn_count", 32'(uturn_count), mon_e.uc);
    end
  end

  initial begin
    model_reset();
    #12;
    check_eq("rst_pos_x", 32'(pos_x), 4);
    check_eq("rst_pos_y", 32'(pos_y), 0);
    check_eq("rst_heading", 32'(heading), 0);
    check_eq("rst_left", 32'(left), 0);
    check_eq("rst_mid", 32'(mid), 0);
    check_eq("rst_right", 32'(right), 0);
    check_eq("rst_at_exit", 32'(at_exit), 0);
    check_eq("rst_fault", 32'(fault), 0);
    check_eq("rst_move_count", 32'(move_count), 0);
    release_reset();

    // Straight run to the exit on an empty map; moves in DONE are ignored.
    do_start();
    repeat (8) do_move(1);
    check_state("exit", 4, 8, 0, 8, 0, 1, 0);
    check_eq("exit_mid_edge", 32'(mid), 1);
    do_move(1);
    check_state("done_hold", 4, 8, 0, 8, 0, 1, 0);

    // Reset during a run clears the map and returns to the start cell.
    apply_reset();
    release_reset();
    do_write(13, 4'b1010);
    do_start();
    repeat (3) do_move(1);
    apply_reset();
    check_eq("midrst_pos_x", 32'(pos_x), 4);
    check_eq("midrst_pos_y", 32'(pos_y), 0);
    check_eq("midrst_at_exit", 32'(at_exit), 0);
    check_eq("midrst_fault", 32'(fault), 0);
    check_eq("midrst_move_count", 32'(move_count), 0);
    release_reset();
    do_start();
    do_move(1);
    check_state("map_cleared", 4, 1, 0, 1, 0, 0, 0);
    check_eq("map_cleared_left", 32'(left), 0);
    check_eq("map_cleared_right", 32'(right), 0);

    // North wall at the start cell.
    apply_reset();
    release_reset();
    do_write(4, 4'b0001);
    do_start();
    @(negedge clk);
    check_eq("nwall_mid", 32'(mid), 1);
    check_eq("nwall_left", 32'(left), 0);
    check_eq("nwall_right", 32'(right), 0);
    do_move(1);
    if (WallCheck) check_state("nwall_fwd", 4, 0, 0, 0, 0, 0, 1);
    else           check_state("nwall_fwd", 4, 1, 0, 1, 0, 0, 0);
    do_move(7);
    do_start();

    // RIGHT then U_TURN.
    do_move(3);
    check_state("right", 5, 0, 1, 1, 0, 0, 0);
    do_move(4);
    check_state("uturn", 4, 0, 3, 2, 1, 0, 0);

    // Illegal code faults and holds state; writes ignored in FAULT; restart keeps the map.
    do_move(6);
    check_state("bad_code", 4, 0, 3, 2, 1, 0, 1);
    do_write(0, 4'b0001);
    do_start();
    check_state("restart", 4, 0, 0, 0, 0, 0, 0);
    check_eq("restart_map_mid", 32'(mid), 1);

    // STOP is not counted; off-grid LEFT at the west edge faults.
    repeat (3) do_move(0);
    check_state("stop", 4, 0, 0, 0, 0, 0, 0);
    do_move(2);
    repeat (3) do_move(1);
    repeat (3) do_move(0);
    check_state("at_x0", 0, 0, 3, 4, 0, 0, 0);
    do_move(2);
    check_state("offgrid", 0, 0, 3, 4, 0, 0, 1);
    check_eq("offgrid_left", 32'(left), 1);
    check_eq("offgrid_mid", 32'(mid), 1);
    check_eq("offgrid_right", 32'(right), 0);

    repeat (2) @(negedge clk);
    check_eq("sb_drain", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
